// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//
// Successive-approximation sequencer for the 12-bit SAR ADC macro. It drives
// the track/hold switch, the capacitive-DAC trial code and the comparator
// latch strobe, resolving one bit per trial, MSB first.
//
// Handshake: a conversion is requested by holding start high while the block
// is in IDLE (level-sampled at the clock edge, gated by ena). The finished
// code is presented on data_out together with a one-cycle data_valid pulse;
// there is no back-pressure, and data_out holds until the next completion.
// A start seen while a conversion is in flight (any state other than IDLE or
// DONE) is dropped and latches the sticky overrun flag.
//
// Parameters:
//   NBITS          resolution; width of dac_code and data_out
//   SAMPLE_CYCLES  cycles sample_en is held high (1..15)
//   SETTLE_CYCLES  DAC settle cycles before each strobe (0..7)
//   COMP_INV       1 = invert comp_in before use
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          block enable; low returns to IDLE on the next edge
//   start        conversion request (level, sampled in IDLE / DONE)
//   cont         continuous mode; restart from DONE without a new start
//   comp_in      comparator decision, 1 = Vin >= DAC (after COMP_INV)
//   sample_en    track/hold switch control
//   comp_strobe  one-cycle comparator latch pulse
//   dac_code     DAC trial code
//   busy         high in any state other than IDLE
//   data_out     last completed conversion
//   data_valid   one-cycle pulse, data_out is new this cycle
//   overrun      sticky: start seen while a conversion was in flight
//   state_dbg    current sequencer state (debug observation only)
//
// All outputs are registered. comp_in is assumed synchronous to clk.
// -----------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int NBITS         = 12,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter bit COMP_INV      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic             comp_in,
    output logic             sample_en,
    output logic             comp_strobe,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_STROBE = 3'd3,
        S_DECIDE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int PW = (NBITS > 1) ? $clog2(NBITS) : 1;

    // Down-counter reload values: a phase lasting N cycles loads N-1 and
    // leaves on the edge where the counter reads zero.
    localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [PW-1:0] PTR_MSB  = PW'(NBITS - 1);

    localparam logic [NBITS-1:0] ONE_CODE = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [NBITS-1:0] MSB_CODE = {1'b1, {(NBITS-1){1'b0}}};

    state_t           state;
    logic [PW-1:0]    ptr;     // bit currently under trial
    logic [NBITS-1:0] trial;   // bits already decided; zero at and below ptr
    logic [3:0]       cnt;     // sample / settle phase counter

    logic             comp_bit;
    logic [NBITS-1:0] bit_mask;
    logic [NBITS-1:0] trial_decided;
    logic [NBITS-1:0] next_code;

    assign comp_bit      = comp_in ^ COMP_INV;
    assign bit_mask      = ONE_CODE << ptr;
    // Bitwise only: the decision touches just the bit under trial.
    assign trial_decided = comp_bit ? (trial | bit_mask) : (trial & ~bit_mask);
    // Trial code for the following bit, presented on entry to its settle/strobe.
    assign next_code     = trial_decided | (bit_mask >> 1);

    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= PTR_MSB;
            trial       <= '0;
            cnt         <= '0;
            sample_en   <= 1'b0;
            comp_strobe <= 1'b0;
            dac_code    <= '0;
            busy        <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Pulse outputs default low; the branches below raise them for
            // exactly the cycle they belong to.
            comp_strobe <= 1'b0;
            data_valid  <= 1'b0;

            if (start && (state != S_IDLE) && (state != S_DONE)) begin
                overrun <= 1'b1;
            end

            if (!ena) begin
                // Abort: return to IDLE without publishing a result. data_out
                // and the sticky overrun flag are kept.
                state     <= S_IDLE;
                sample_en <= 1'b0;
                dac_code  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_SAMPLE;
                            trial     <= '0;
                            ptr       <= PTR_MSB;
                            cnt       <= SAMPLE_LOAD;
                            overrun   <= 1'b0;
                            sample_en <= 1'b1;
                            busy      <= 1'b1;
                            dac_code  <= '0;
                        end
                    end

                    S_SAMPLE: begin
                        if (cnt == 4'd0) begin
                            sample_en <= 1'b0;
                            dac_code  <= MSB_CODE;
                            if (SETTLE_CYCLES == 0) begin
                                state       <= S_STROBE;
                                comp_strobe <= 1'b1;
                            end else begin
                                state <= S_SETTLE;
                                cnt   <= SETTLE_LOAD;
                            end
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end

                    S_SETTLE: begin
                        if (cnt == 4'd0) begin
                            state       <= S_STROBE;
                            comp_strobe <= 1'b1;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end

                    S_STROBE: begin
                        // Comparator latches during this cycle; its decision
                        // is read in DECIDE.
                        state <= S_DECIDE;
                    end

                    S_DECIDE: begin
                        trial <= trial_decided;
                        if (ptr == '0) begin
                            state    <= S_DONE;
                            dac_code <= trial_decided;
                        end else begin
                            ptr      <= ptr - PW'(1);
                            dac_code <= next_code;
                            if (SETTLE_CYCLES == 0) begin
                                state       <= S_STROBE;
                                comp_strobe <= 1'b1;
                            end else begin
                                state <= S_SETTLE;
                                cnt   <= SETTLE_LOAD;
                            end
                        end
                    end

                    S_DONE: begin
                        // Result is published on the edge leaving DONE, so the
                        // valid pulse lines up with the new data_out.
                        data_out   <= trial;
                        data_valid <= 1'b1;
                        if (cont || start) begin
                            state     <= S_SAMPLE;
                            trial     <= '0;
                            ptr       <= PTR_MSB;
                            cnt       <= SAMPLE_LOAD;
                            sample_en <= 1'b1;
                            dac_code  <= '0;
                        end else begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            dac_code <= '0;
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        sample_en <= 1'b0;
                        dac_code  <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
//
// Two instances: u_std (defaults) and u_fast (SETTLE_CYCLES=0, COMP_INV=1).
// Each sees a comparator model: decision = (Vin >= dac_code), forced 1 or 0
// in the tied modes, and inverted on the pin of u_fast. The reference model
// treats a conversion as "the result is Vin" and the trial at step k as
// "the top k bits of Vin followed by a single 1".
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals (index 0 = u_std, 1 = u_fast) ----------------
    logic        ena_a[2];
    logic        start_a[2];
    logic        cont_a[2];
    logic        comp_a[2];
    logic        samp_a[2];
    logic        strb_a[2];
    logic        busy_a[2];
    logic        dv_a[2];
    logic        ovr_a[2];
    logic [11:0] dac_a[2];
    logic [11:0] dout_a[2];
    logic [2:0]  dbg_a[2];

    logic [11:0] vin_a[2];
    int          mode_a[2];   // 0 = comparator model, 1 = tied high, 2 = tied low
    int          lat[2] = '{41, 29};

    function automatic logic decide(input int mode, input logic [11:0] vin, input logic [11:0] dac);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (vin >= dac);
    endfunction

    assign comp_a[0] = decide(mode_a[0], vin_a[0], dac_a[0]);
    assign comp_a[1] = ~decide(mode_a[1], vin_a[1], dac_a[1]);

    sar_adc_ctrl #(.NBITS(12), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1), .COMP_INV(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .ena(ena_a[0]), .start(start_a[0]), .cont(cont_a[0]),
        .comp_in(comp_a[0]), .sample_en(samp_a[0]), .comp_strobe(strb_a[0]),
        .dac_code(dac_a[0]), .busy(busy_a[0]), .data_out(dout_a[0]),
        .data_valid(dv_a[0]), .overrun(ovr_a[0]), .state_dbg(dbg_a[0])
    );

    sar_adc_ctrl #(.NBITS(12), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(0), .COMP_INV(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_n), .ena(ena_a[1]), .start(start_a[1]), .cont(cont_a[1]),
        .comp_in(comp_a[1]), .sample_en(samp_a[1]), .comp_strobe(strb_a[1]),
        .dac_code(dac_a[1]), .busy(busy_a[1]), .data_out(dout_a[1]),
        .data_valid(dv_a[1]), .overrun(ovr_a[1]), .state_dbg(dbg_a[1])
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int          exp_due_q[$];
    int          exp_dut_q[$];
    logic [11:0] exp_trial_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          strobe_cnt[2] = '{0, 0};
    int          sample_cnt[2] = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        exp_due_q.delete();
        exp_dut_q.delete();
        exp_trial_q.delete();
        strobe_cnt = '{0, 0};
        sample_cnt = '{0, 0};
    endtask

    // Expected result and trial sequence for one conversion of Vin.
    task automatic push_conv(input int d, input logic [11:0] v, input int due);
        exp_q.push_back(v);
        exp_due_q.push_back(due);
        exp_dut_q.push_back(d);
        for (int k = 0; k < 12; k++) begin
            int hi;
            hi = 4096 - (1 << (12 - k));
            exp_trial_q.push_back(12'((int'(v) & hi) | (1 << (11 - k))));
        end
    endtask

    // ---------------- monitor ----------------
    logic [11:0] mon_code;
    int          mon_due;
    int          mon_dut;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (dv_a[d]) begin
                    check("dv_pending", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        mon_code = exp_q.pop_front();
                        mon_due  = exp_due_q.pop_front();
                        mon_dut  = exp_dut_q.pop_front();
                        check("dv_instance", d, mon_dut);
                        check("data_out", dout_a[d], mon_code);
                        check("latency_cycle", cyc, mon_due);
                        check("strobe_count", strobe_cnt[d], 12);
                        check("sample_cycles", sample_cnt[d], 4);
                    end
                    strobe_cnt[d] = 0;
                    sample_cnt[d] = 0;
                end
                if (strb_a[d]) begin
                    strobe_cnt[d]++;
                    if (exp_trial_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL trial_pending: strobe with dac 0x%0h, expected no strobe", dac_a[d]);
                    end else begin
                        check("trial_code", dac_a[d], exp_trial_q.pop_front());
                    end
                end
                if (samp_a[d]) sample_cnt[d]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_conv(input int d, input logic [11:0] v, input int mode, output int acc);
        logic [11:0] eff;
        @(negedge clk);
        vin_a[d]   = v;
        mode_a[d]  = mode;
        start_a[d] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        eff = (mode == 1) ? 12'hFFF : (mode == 2) ? 12'h000 : v;
        push_conv(d, eff, acc + lat[d]);
        @(negedge clk);
        start_a[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy_a[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy_a[d], 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input int d, input string name);
        check(name, {samp_a[d], strb_a[d], dac_a[d], busy_a[d], dout_a[d], dv_a[d], ovr_a[d]}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int got;
        int busy_low;
        int dv_seen;
        logic [11:0] v;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ena_a[d] = 1'b1; start_a[d] = 1'b0; cont_a[d] = 1'b0;
            vin_a[d] = '0;   mode_a[d] = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero(0, "reset_std");
        check_all_zero(1, "reset_fast");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero(0, "idle_std");

        // Comparator model, Vin = 0xA5C
        start_conv(0, 12'hA5C, 0, acc);
        wait_idle(0);

        // Tied comparator: all ones / all zeros
        start_conv(0, 12'h000, 1, acc);
        wait_idle(0);
        start_conv(0, 12'h000, 2, acc);
        wait_idle(0);

        // Randomized conversions on the default instance
        for (int i = 0; i < 6; i++) begin
            start_conv(0, 12'($urandom_range(0, 4095)), 0, acc);
            wait_idle(0);
        end

        // Continuous mode: three back-to-back conversions
        cont_a[0] = 1'b1;
        start_conv(0, 12'h001, 0, acc);
        push_conv(0, 12'h7FF, acc + 82);
        push_conv(0, 12'h800, acc + 123);
        got = 0;
        busy_low = 0;
        for (int c = 0; c < 140 && got < 3; c++) begin
            @(negedge clk);
            if (dv_a[0]) begin
                got++;
                if (got == 1) vin_a[0] = 12'h7FF;
                if (got == 2) begin
                    vin_a[0]  = 12'h800;
                    cont_a[0] = 1'b0;
                end
            end else if (!busy_a[0]) begin
                busy_low++;
            end
        end
        check("cont_valid_count", got, 3);
        check("cont_busy_drops", busy_low, 0);
        @(negedge clk);
        check("overrun_clear", ovr_a[0], 0);

        // start pulsed during the bit-5 trial
        start_conv(0, 12'($urandom_range(0, 4095)), 0, acc);
        while (cyc < acc + 22) @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        check("overrun_set", ovr_a[0], 1);
        wait_idle(0);
        check("overrun_sticky", ovr_a[0], 1);
        start_conv(0, 12'h5A3, 0, acc);
        check("overrun_cleared_on_start", ovr_a[0], 0);
        wait_idle(0);

        // Async reset while the comparator strobe is high
        start_conv(0, 12'h1B7, 0, acc);
        for (int n = 0; n < 60 && !strb_a[0]; n++) @(negedge clk);
        check("strobe_seen", strb_a[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "async_reset_std");
        check("async_reset_fast_dout", dout_a[1], 0);
        flush();
        @(negedge clk);
        rst_n = 1'b1;
        start_conv(0, 12'h3C5, 0, acc);
        wait_idle(0);

        // ena low during SETTLE: abort, keep data_out
        start_conv(0, 12'h9A1, 0, acc);
        while (cyc < acc + 4) @(negedge clk);
        ena_a[0] = 1'b0;
        @(posedge clk);
        #1;
        flush();
        @(negedge clk);
        check("abort_busy", busy_a[0], 0);
        check("abort_sample_en", samp_a[0], 0);
        check("abort_strobe", strb_a[0], 0);
        check("abort_dout_kept", dout_a[0], 12'h3C5);
        dv_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (dv_a[0]) dv_seen++;
        end
        check("abort_no_valid", dv_seen, 0);
        ena_a[0] = 1'b1;

        // Fast instance: no settle, inverted comparator
        start_conv(1, 12'hA5C, 0, acc);
        wait_idle(1);
        start_conv(1, 12'h000, 1, acc);
        wait_idle(1);
        for (int i = 0; i < 5; i++) begin
            v = 12'($urandom_range(0, 4095));
            start_conv(1, v, 0, acc);
            wait_idle(1);
        end
        start_conv(1, 12'hA5C, 0, acc);
        wait_idle(1);

        // Fast instance abort mid-conversion
        start_conv(1, 12'h2E4, 0, acc);
        while (cyc < acc + 6) @(negedge clk);
        ena_a[1] = 1'b0;
        @(posedge clk);
        #1;
        flush();
        @(negedge clk);
        check("fast_abort_busy", busy_a[1], 0);
        check("fast_abort_strobe", strb_a[1], 0);
        check("fast_abort_dout_kept", dout_a[1], 12'hA5C);
        dv_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dv_a[1]) dv_seen++;
        end
        check("fast_abort_no_valid", dv_seen, 0);
        ena_a[1] = 1'b1;

        repeat (3) @(negedge clk);
        check("results_drained", exp_q.size(), 0);
        check("trials_drained", exp_trial_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
